// File: rtl/osd_write_arbiter_pkg.sv
// Shared constants, FSM state type and the hex-to-ASCII helper for the OSD write arbiter.
package osd_pkg;

    localparam int OSD_NUM_REQ = 4;
    localparam int OSD_COLS    = 16;
    localparam int OSD_ROWS    = 8;
    localparam int OSD_ADDR_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO
    } state_e;

    // Digits 0-9 map to '0'-'9'; A-F map to uppercase 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/osd_write_arbiter_if.sv
// Request/response and text_buffer write bundle between debug-value sources and the arbiter.
interface osd_write_arbiter_if
    import osd_pkg::*;
#(
    parameter int NUM_REQ = OSD_NUM_REQ,
    parameter int ADDR_W  = OSD_ADDR_W
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*4-1:0] req_line;
    logic [NUM_REQ*5-1:0] req_col;
    logic [NUM_REQ*8-1:0] req_value;
    logic [NUM_REQ-1:0]   req_done;
    logic [NUM_REQ-1:0]   req_err;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [7:0]           wr_data;
    logic                 busy;

    modport master (
        output req_valid, req_line, req_col, req_value,
        input  req_done, req_err, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        input  req_valid, req_line, req_col, req_value,
        output req_done, req_err, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/osd_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index strictly after the last grant.
module osd_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_pending_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_i) + k) % NUM_REQ;
            if (!found && pending_i[idx]) begin
                grant_o = IDX_W'(idx);
                found   = 1'b1;
            end
        end
    end

    assign any_pending_o = |pending_i;

endmodule

// File: rtl/osd_write_arbiter.sv
// Round-robin arbiter sharing the OSD text_buffer write port; each granted byte becomes two hex characters.
module osd_write_arbiter
    import osd_pkg::*;
#(
    parameter int NUM_REQ = OSD_NUM_REQ,
    parameter int COLS    = OSD_COLS,
    parameter int ROWS    = OSD_ROWS,
    parameter int ADDR_W  = OSD_ADDR_W,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic                clk,
    input logic                reset,
    osd_write_arbiter_if.slave bus
);

    state_e             state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [3:0]         line_q  [NUM_REQ];
    logic [4:0]         col_q   [NUM_REQ];
    logic [7:0]         value_q [NUM_REQ];
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  base_q;
    logic [7:0]         val_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic               busy_q;

    logic [IDX_W-1:0]   grant_d;
    logic               any_pending_d;
    logic [NUM_REQ-1:0] pos_ok_d;
    logic [ADDR_W-1:0]  base_d;

    osd_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .pending_i    (pending_q),
        .last_i       (last_q),
        .grant_o      (grant_d),
        .any_pending_o(any_pending_d)
    );

    // Both characters must land on the same line, so the last usable column is COLS-2.
    always_comb begin
        pos_ok_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_ok_d[i] = (int'(bus.req_line[4*i +: 4]) < ROWS) &&
                          (int'(bus.req_col[5*i +: 5]) <= COLS - 2);
        end
    end

    assign base_d = ADDR_W'(line_q[grant_d]) * ADDR_W'(COLS) + ADDR_W'(col_q[grant_d]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            base_q    <= '0;
            val_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                line_q[i]  <= '0;
                col_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= '0;
            busy_q    <= (state_q != IDLE) || (|pending_q);

            case (state_q)
                IDLE: begin
                    if (any_pending_d) begin
                        base_q             <= base_d;
                        val_q              <= value_q[grant_d];
                        grant_q            <= grant_d;
                        pending_q[grant_d] <= 1'b0;
                        state_q            <= HI;
                    end
                end
                HI: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= base_q;
                    wr_data_q <= nibble_to_ascii(val_q[7:4]);
                    state_q   <= LO;
                end
                LO: begin
                    wr_en_q         <= 1'b1;
                    wr_addr_q       <= base_q + ADDR_W'(1);
                    wr_data_q       <= nibble_to_ascii(val_q[3:0]);
                    done_q[grant_q] <= 1'b1;
                    last_q          <= grant_q;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Loads come after the pick so a same-cycle re-strobe re-arms the slot just granted.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i]) begin
                    if (pos_ok_d[i]) begin
                        line_q[i]    <= bus.req_line[4*i +: 4];
                        col_q[i]     <= bus.req_col[5*i +: 5];
                        value_q[i]   <= bus.req_value[8*i +: 8];
                        pending_q[i] <= 1'b1;
                    end else begin
                        err_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.req_done = done_q;
    assign bus.req_err  = err_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/osd_write_arbiter.md
Name: osd_write_arbiter

Overview:
- Shares the single write port of the OSD text_buffer between NUM_REQ debug-value requesters, e.g. the hoffset and voffset hex writers.
- Each requester posts a (line, column, 8-bit value) update. The block queues one update per requester and arbitrates round-robin.
- For each granted update it emits two sequential buffer writes: the ASCII hex high nibble, then the low nibble.
- Sits between the debug-value sources and the text_buffer; the text_renderer read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters.
- COLS, 16, characters per OSD line.
- ROWS, 8, OSD lines.
- ADDR_W, 7, text_buffer address width; COLS*ROWS <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  one-cycle request strobe per requester.
- req_line  in  NUM_REQ*4  flattened line index; requester i uses bits [4i+3:4i].
- req_col  in  NUM_REQ*5  flattened column index.
- req_value  in  NUM_REQ*8  flattened byte to display.
- req_done  out  NUM_REQ  one-cycle pulse when requester i's low-nibble write issues.
- req_err  out  NUM_REQ  sticky: requester i posted an out-of-range position.
- wr_en  out  1  text_buffer write enable.
- wr_addr  out  ADDR_W  text_buffer write address.
- wr_data  out  8  ASCII character.
- busy  out  1  high whenever the FSM is not in IDLE or any slot is pending.

Behaviour:
- Reset values: all outputs 0; pending slots cleared; round-robin pointer set to requester NUM_REQ-1, so requester 0 has first priority; FSM in IDLE.
- Per-requester slot holding pending, line, col and value.
  - req_valid[i] loads the slot and sets pending.
  - If the slot is already pending and not yet granted, it is overwritten (latest value wins, no error).
- Range check at load:
  - Invalid if line >= ROWS or col > COLS-2, because the two characters must stay on one line.
  - An invalid request is discarded, sets req_err[i] and does not touch the slot.
  - req_err clears only on reset.
- FSM, all outputs registered:
  - IDLE: if any slot is pending, pick the first pending index after the last grant (wrap-around). Latch base = line*COLS + col and value into working registers, clear that slot's pending bit, go to HI. Otherwise stay in IDLE.
  - HI: wr_en=1, wr_addr=base, wr_data=ascii(value[7:4]); go to LO.
  - LO: wr_en=1, wr_addr=base+1, wr_data=ascii(value[3:0]); pulse req_done[grant]; update the pointer to grant; go to IDLE.
- Registered outputs appear one cycle after the state. Latency from req_valid to the first wr_en is 3 cycles when idle: load, IDLE pick, HI output. Sustained throughput is 3 cycles per update.
- ASCII mapping: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).
- req_valid[i] in the same cycle that slot i is picked: the new request sets pending again and is served on a later round. The in-flight update uses the old latched value.
- Simultaneous requests from all requesters: each is served exactly once, in round-robin order; none starves.
- wr_en is never high in two consecutive cycles for different requesters without the intervening IDLE cycle.
- Reset mid-operation: wr_en is 0 on the next cycle; the partial update is abandoned (a high nibble may remain in the buffer); no req_done pulse.
- Address arithmetic is done at ADDR_W width and never wraps, given the range check.

Decomposition:
- Package osd_pkg holds:
  - constants OSD_COLS, OSD_ROWS, OSD_ADDR_W;
  - state enum {IDLE, HI, LO};
  - function nibble_to_ascii.
- One sub-module, osd_rr_pick: combinational round-robin selector taking pending[NUM_REQ] and the last-grant pointer, producing grant index and any_pending.

Test Plan:
- Requester 0 posts line 1, col 8, value 0x3C -> writes addr 24 data 0x33, then addr 25 data 0x43; req_done[0] pulses; first wr_en arrives 3 cycles after the strobe.
- Requesters 0-3 strobe together with values 0x00/0x11/0xAB/0xFF at distinct positions -> updates served in order 0,1,2,3; 8 writes total; four req_done pulses; busy falls after the last LO.
- Requester 2 posts 0x12 then 0x9F before being granted -> only 0x39,0x46 are written; exactly one req_done[2].
- Requester 1 posts col 15 (COLS-1), or line 8 -> no writes; req_err[1]=1 and stays 1 until reset.
- Requester 0 re-strobes with 0x55 during its own IDLE pick cycle -> the in-flight update completes with the old value, then 0x35,0x35 is written.
- Reset asserted during HI -> wr_en=0 the next cycle, busy=0, no req_done; a new request afterwards completes normally.
